// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and FSM state type for the in-place radix-2 FFT sequencer
package fft_pkg;
    localparam int LOG2N_DEF = 10;
    localparam int CPLX_W = 64;
    localparam int TW_W = 32;
    localparam int BFLY_LATENCY = 8;
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, NEXT, FINISH} state_t;
endpackage

// File: rtl/clock_delay.sv
// clock_delay: DEPTH-cycle shift register with synchronous clear of every tap
module clock_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sr_q [DEPTH];
    logic [WIDTH-1:0] sr_d [DEPTH];
    always_comb begin
        sr_d[0] = d;
        for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end
    assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: maps (stage, butterfly j) to the two operand addresses and twiddle index
module fft_addr_gen #(
    parameter int LOG2N = fft_pkg::LOG2N_DEF
) (
    input  logic [LOG2N-1:0] stage,
    input  logic [LOG2N-2:0] j,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_addr
);
    import fft_pkg::*;
    localparam logic [LOG2N-2:0] J_ONE = 1;
    localparam logic [LOG2N-1:0] A_ONE = 1;
    logic [LOG2N-2:0] pos;
    logic [LOG2N-1:0] sh;
    // In the last stage 1<<s overflows to 0, so the mask becomes all ones as required
    always_comb begin
        pos = j & ((J_ONE << stage) - J_ONE);
        sh = LOG2N'(LOG2N - 1) - stage;
        tw_addr = pos << sh;
        addr_a = (({1'b0, j} >> stage) << (stage + A_ONE)) | {1'b0, pos};
        addr_b = addr_a + (A_ONE << stage);
    end
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: walks LOG2N radix-2 stages, issuing reads and delayed write-backs
// Optional issue stall via `define FFT_STAGE_SEQUENCER_HOLD_EN (adds input hold).
module fft_stage_sequencer #(
    parameter int LOG2N = fft_pkg::LOG2N_DEF,
    parameter int RD_LATENCY = 1,
    parameter int BFLY_LATENCY = fft_pkg::BFLY_LATENCY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef FFT_STAGE_SEQUENCER_HOLD_EN
    input  logic             hold,
`endif
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
);
    import fft_pkg::*;
    localparam int D = RD_LATENCY + BFLY_LATENCY;
    localparam int CW = $clog2(D + 1);
    localparam int WBW = 2 * LOG2N + 1;
    localparam logic [LOG2N-2:0] J_ONE = 1;
    localparam logic [LOG2N-1:0] S_ONE = 1;
    localparam logic [CW-1:0] C_ONE = 1;
    state_t state_q, state_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [LOG2N-2:0] j_q, j_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic busy_q, busy_d, done_q, done_d, hold_i;
    logic [LOG2N-1:0] rd_addr_a_q, rd_addr_b_q, addr_a_d, addr_b_d;
    logic [LOG2N-2:0] tw_addr_q, tw_d;
    logic [WBW-1:0] wb_q;
`ifdef FFT_STAGE_SEQUENCER_HOLD_EN
    assign hold_i = hold;
`else
    assign hold_i = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d = j_q;
        cnt_d = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                stage_d = '0;
                j_d = '0;
                busy_d = 1'b1;
            end
            RUN: if (!hold_i) begin
                if (j_q == '1) begin
                    state_d = DRAIN;
                    cnt_d = CW'(D - 1);
                end else begin
                    j_d = j_q + J_ONE;
                end
            end
            // Wait out the read + butterfly pipeline so the next stage never reads stale data
            DRAIN: if (cnt_q != '0) begin
                cnt_d = cnt_q - C_ONE;
            end else if (stage_q == LOG2N'(LOG2N - 1)) begin
                state_d = FINISH;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                state_d = NEXT;
            end
            NEXT: begin
                state_d = RUN;
                stage_d = stage_q + S_ONE;
                j_d = '0;
            end
            FINISH: begin
                state_d = IDLE;
                stage_d = '0;
                j_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    fft_addr_gen #(.LOG2N(LOG2N)) u_addr (
        .stage   (stage_d),
        .j       (j_d),
        .addr_a  (addr_a_d),
        .addr_b  (addr_b_d),
        .tw_addr (tw_d)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            j_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q <= j_d;
            cnt_q <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rd_addr_a_q <= addr_a_d;
            rd_addr_b_q <= addr_b_d;
            tw_addr_q <= tw_d;
        end
    end
    assign rd_en = (state_q == RUN) && !hold_i;
    clock_delay #(.WIDTH(WBW), .DEPTH(D)) u_wb (
        .clk (clk),
        .clr (!rst_n),
        .d   ({rd_en, rd_addr_a_q, rd_addr_b_q}),
        .q   (wb_q)
    );
    assign {wr_en, wr_addr_a, wr_addr_b} = wb_q;
    assign busy = busy_q;
    assign done = done_q;
    assign stage = stage_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_addr = tw_addr_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: scoreboard bench with an FFT loop-nest reference model
module tb_fft_stage_sequencer;
    localparam int LOG2N = 3;
    localparam int N = 8;
    localparam int D = 9;
    localparam int STAGE_CYC = N / 2 + D + 1;
    typedef struct packed {
        logic [31:0] t;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [1:0]  tw;
        logic [2:0]  st;
    } ev_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
`ifdef FFT_STAGE_SEQUENCER_HOLD_EN
    logic hold = 1'b0;
`endif
    logic busy, done, rd_en, wr_en;
    logic [2:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0] tw_addr;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    bit first_rd = 1'b1;
    int last_wr_t = -1;
    int n_rd = 0;
    int n_wr = 0;
    logic [2:0] prev_st = '0;
    ev_t rd_q[$];
    ev_t wr_q[$];
    int done_q[$];
    ev_t e, g;
    int de;

    fft_stage_sequencer #(.LOG2N(LOG2N), .RD_LATENCY(1), .BFLY_LATENCY(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef FFT_STAGE_SEQUENCER_HOLD_EN
        .hold      (hold),
`endif
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected reads follow the textbook loop nest: groups of 2*half, pairs (k+p, k+p+half), twiddle p*N/(2*half)
    task automatic model(input int c0, input int h);
        int t, half, idx;
        for (int s = 0; s < LOG2N; s++) begin
            half = 1 << s;
            idx = 0;
            for (int k = 0; k < N; k += 2 * half) begin
                for (int p = 0; p < half; p++) begin
                    t = c0 + 1 + s * STAGE_CYC + idx + ((s > 0 || idx >= 2) ? h : 0);
                    rd_q.push_back({32'(t), 3'(k + p), 3'(k + p + half), 2'(p * (N / (2 * half))), 3'(s)});
                    wr_q.push_back({32'(t + D), 3'(k + p), 3'(k + p + half), 2'b0, 3'b0});
                    idx++;
                end
            end
        end
        done_q.push_back(c0 + LOG2N * STAGE_CYC + h);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en) begin
                if (first_rd || stage != prev_st)
                    chk("stage_boundary_drained", {30'b0, cyc > last_wr_t, n_rd == n_wr}, 64'd3);
                first_rd = 1'b0;
                prev_st = stage;
                n_rd++;
                g = {cyc, rd_addr_a, rd_addr_b, tw_addr, stage};
                if (rd_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_event", g, e);
                end
            end
            if (wr_en) begin
                chk("wr_busy", {63'b0, busy}, 64'd1);
                last_wr_t = cyc;
                n_wr++;
                g = {cyc, wr_addr_a, wr_addr_b, 2'b0, 3'b0};
                if (wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_event", g, e);
                end
            end
            if (done) begin
                chk("done_busy", {63'b0, busy}, 64'd0);
                if (done_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
                else begin
                    de = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(de));
                end
            end
        end
    end

    task automatic run(input bit use_hold);
        int c0, h, last;
        h = use_hold ? 3 : 0;
        @(posedge clk);
        #1;
        c0 = cyc;
        last = c0 + LOG2N * STAGE_CYC + h;
        n_rd = 0;
        n_wr = 0;
        first_rd = 1'b1;
        model(c0, h);
        start = 1'b1;
        for (int i = 0; i < LOG2N * STAGE_CYC + h + 2; i++) begin
            @(posedge clk);
            #1;
            start = (cyc <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef FFT_STAGE_SEQUENCER_HOLD_EN
            hold = use_hold && cyc >= c0 + 3 && cyc <= c0 + 5;
`endif
        end
        start = 1'b0;
        chk("rd_all_seen", 64'(rd_q.size()), 64'd0);
        chk("wr_all_seen", 64'(wr_q.size()), 64'd0);
        chk("done_seen", 64'(done_q.size()), 64'd0);
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
    endtask

    task automatic mid_reset();
        int k;
        k = 0;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (stage != 3'd1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("reach_stage1", {61'b0, stage}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_outputs", {rd_en, wr_en, busy, done, stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_quiet", {61'b0, wr_en, rd_en, busy}, 64'd0);
        end
        last_wr_t = -1;
        mon_en = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en", {63'b0, rd_en}, 64'd0);
        chk("rst_wr_en", {63'b0, wr_en}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_stage", {61'b0, stage}, 64'd0);
        chk("rst_rd_addr_a", {61'b0, rd_addr_a}, 64'd0);
        chk("rst_rd_addr_b", {61'b0, rd_addr_b}, 64'd0);
        chk("rst_tw_addr", {62'b0, tw_addr}, 64'd0);
        chk("rst_wr_addr_a", {61'b0, wr_addr_a}, 64'd0);
        chk("rst_wr_addr_b", {61'b0, wr_addr_b}, 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        run(1'b0);
        repeat ($urandom_range(0, 4)) @(posedge clk);
        run(1'b0);
`ifdef FFT_STAGE_SEQUENCER_HOLD_EN
        repeat ($urandom_range(0, 4)) @(posedge clk);
        run(1'b1);
`endif
        mid_reset();
        run(1'b0);
        repeat ($urandom_range(0, 4)) @(posedge clk);
        run(1'b0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
